// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared definitions for the two-port SRAM arbiter.
//   PORT_INST / PORT_DATA : port identifiers used for grant ownership and prio
//   RD_LAT_MAX            : largest supported SRAM read latency
//   rsp_entry_t           : one response-tracking slot {valid, owner}
package sram_arb_pkg;

  localparam logic PORT_INST = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  localparam int RD_LAT_MAX = 4;

  typedef struct packed {
    logic valid;
    logic owner;
  } rsp_entry_t;

endpackage : sram_arb_pkg

// File: rtl/sram_rsp_pipe.sv
// sram_rsp_pipe: RD_LAT-deep shift register of {valid, owner} entries that
// tracks which port owns each in-flight SRAM access.
//   clk        : clock, rising edge
//   reset      : asynchronous active-low clear (all entries invalid)
//   push_valid : an access is issued this cycle
//   push_owner : port that owns the issued access
//   tail       : entry that has aged RD_LAT cycles (response due now)
module sram_rsp_pipe
  import sram_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_valid,
  input  logic       push_owner,
  output rsp_entry_t tail
);

  rsp_entry_t stage [RD_LAT];

  // Entry pushed at the end of grant cycle t sits in stage[RD_LAT-1]
  // during cycle t+RD_LAT, lining up with the SRAM read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage[i] <= '{valid: 1'b0, owner: PORT_DATA};
      end
    end else begin
      stage[0] <= '{valid: push_valid, owner: push_owner};
      for (int i = 1; i < RD_LAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tail = stage[RD_LAT-1];

endmodule : sram_rsp_pipe

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one synchronous single-port SRAM between the
// instruction-fetch port and the data port with 2-way round-robin arbitration.
//   clk, reset                 : clock; asynchronous active-low reset
//   inst_req/wen/addr/wdata    : inst port request (wen=0 means read)
//   inst_ack                   : inst request accepted this cycle (combinational)
//   inst_rvalid/inst_rdata     : inst response pulse, RD_LAT cycles after ack
//   data_*                     : data port, same meaning as inst_*
//   mem_en/wen/addr/wdata      : SRAM command for the winning port
//   mem_rdata                  : SRAM read data, valid RD_LAT cycles after mem_en
//   conflict_cnt               : saturating count of cycles with both requests
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inst_req,
  input  logic [3:0]      inst_wen,
  input  logic [XLEN-1:0] inst_addr,
  input  logic [XLEN-1:0] inst_wdata,
  output logic            inst_ack,
  output logic            inst_rvalid,
  output logic [XLEN-1:0] inst_rdata,
  input  logic            data_req,
  input  logic [3:0]      data_wen,
  input  logic [XLEN-1:0] data_addr,
  input  logic [XLEN-1:0] data_wdata,
  output logic            data_ack,
  output logic            data_rvalid,
  output logic [XLEN-1:0] data_rdata,
  output logic            mem_en,
  output logic [3:0]      mem_wen,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [31:0]     conflict_cnt
);

  // Tracking depth clamped into the supported range so a bad override
  // cannot produce a zero-length or oversized pipe.
  localparam int PIPE_DEPTH = (RD_LAT < 1) ? 1 :
                              (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  logic       prio;
  logic       req_both;
  logic       grant_inst;
  logic       grant_data;
  logic       grant_any;
  rsp_entry_t rsp_tail;

  assign req_both = inst_req & data_req;

  // Lone requester always wins; under contention prio decides. Everything
  // is forced idle while reset is held low.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (reset) begin
      if (req_both) begin
        grant_data = (prio == PORT_DATA);
        grant_inst = (prio == PORT_INST);
      end else begin
        grant_inst = inst_req;
        grant_data = data_req;
      end
    end
  end

  assign grant_any = grant_inst | grant_data;
  assign inst_ack  = grant_inst;
  assign data_ack  = grant_data;

  // After any grant, priority passes to the port that did not win.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio <= PORT_DATA;
    end else if (grant_any) begin
      prio <= grant_data ? PORT_INST : PORT_DATA;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_cnt <= '0;
    end else if (req_both && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

  // Winner's command onto the SRAM; all-zero when idle.
  always_comb begin
    mem_en    = grant_any;
    mem_wen   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_data) begin
      mem_wen   = data_wen;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else if (grant_inst) begin
      mem_wen   = inst_wen;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end
  end

  sram_rsp_pipe #(
    .RD_LAT (PIPE_DEPTH)
  ) u_rsp_pipe (
    .clk        (clk),
    .reset      (reset),
    .push_valid (grant_any),
    .push_owner (grant_data ? PORT_DATA : PORT_INST),
    .tail       (rsp_tail)
  );

  // Writes also retire through the pipe; their rdata is meaningless but
  // the pulse tells the port the write has completed.
  assign inst_rvalid = rsp_tail.valid && (rsp_tail.owner == PORT_INST);
  assign data_rvalid = rsp_tail.valid && (rsp_tail.owner == PORT_DATA);
  assign inst_rdata  = inst_rvalid ? mem_rdata : '0;
  assign data_rdata  = data_rvalid ? mem_rdata : '0;

endmodule : sram_arbiter

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scenarios plus randomized traffic for
// sram_arbiter (RD_LAT=3), with an SRAM model and a transaction-level
// reference model checked every cycle.
module tb_sram_arbiter;

  localparam int LAT = 3;
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, data_req;
  logic [3:0]  inst_wen, data_wen;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_ack, inst_rvalid, data_ack, data_rvalid;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] conflict_cnt;

  always #5 clk = ~clk;

  sram_arbiter #(.XLEN(32), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wen(inst_wen), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_ack(inst_ack), .inst_rvalid(inst_rvalid),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_ack(data_ack), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  // ---------------- SRAM model: 64 words, read data LAT cycles later
  logic [31:0] sram [64];
  logic [31:0] rd_pipe [LAT];

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) sram[i] <= 32'h0;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_wen[b]) sram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    rd_pipe[0] <= sram[mem_addr[7:2]];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // ---------------- checking bookkeeping
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model
  typedef struct {
    logic        owner;
    logic        is_read;
    logic [31:0] data;
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic        owner;
    int          cyc;
    logic [31:0] data;
  } ev_t;

  pend_t       pend[$];
  ev_t         glog[$];
  ev_t         rlog[$];
  logic [31:0] shadow [64];
  logic        m_prio;
  logic [31:0] m_cnt;
  int          cyc = 0;

  always @(negedge clk) begin
    logic        exp_iv, exp_dv, any, win;
    logic [3:0]  w_wen;
    logic [31:0] w_addr, w_wdata;
    pend_t       e;
    cyc++;
    if (!reset) begin
      chk("rst_inst_ack", {31'b0, inst_ack}, 32'd0);
      chk("rst_data_ack", {31'b0, data_ack}, 32'd0);
      chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
      chk("rst_inst_rvalid", {31'b0, inst_rvalid}, 32'd0);
      chk("rst_data_rvalid", {31'b0, data_rvalid}, 32'd0);
      chk("rst_conflict_cnt", conflict_cnt, 32'd0);
      m_prio = OWN_DATA;
      m_cnt  = 32'd0;
      pend.delete();
      for (int i = 0; i < 64; i++) shadow[i] = 32'h0;
    end else begin
      // responses due this cycle
      exp_iv = 1'b0;
      exp_dv = 1'b0;
      e = '{owner: 1'b0, is_read: 1'b0, data: 32'h0, addr: 32'h0, due: 0};
      if (pend.size() > 0 && pend[0].due == cyc) begin
        e = pend.pop_front();
        if (e.owner == OWN_DATA) exp_dv = 1'b1; else exp_iv = 1'b1;
      end
      chk("inst_rvalid", {31'b0, inst_rvalid}, {31'b0, exp_iv});
      chk("data_rvalid", {31'b0, data_rvalid}, {31'b0, exp_dv});
      if (exp_iv && e.is_read) chk("inst_rdata", inst_rdata, e.data);
      if (!exp_iv)             chk("inst_rdata_idle", inst_rdata, 32'h0);
      if (exp_dv && e.is_read) chk("data_rdata", data_rdata, e.data);
      if (!exp_dv)             chk("data_rdata_idle", data_rdata, 32'h0);
      if (exp_iv || exp_dv) begin
        $display("txn %s %s addr=%h data=%h done cyc=%0d",
                 e.owner ? "data" : "inst", e.is_read ? "rd" : "wr",
                 e.addr, e.is_read ? e.data : 32'h0, cyc);
        rlog.push_back('{owner: e.owner, cyc: cyc, data: e.is_read ? e.data : 32'h0});
      end

      // arbitration: lone requester wins, otherwise whoever prio names
      any = inst_req | data_req;
      win = (inst_req && data_req) ? m_prio : data_req;
      w_wen   = win ? data_wen   : inst_wen;
      w_addr  = win ? data_addr  : inst_addr;
      w_wdata = win ? data_wdata : inst_wdata;
      chk("inst_ack", {31'b0, inst_ack}, {31'b0, any && win == OWN_INST});
      chk("data_ack", {31'b0, data_ack}, {31'b0, any && win == OWN_DATA});
      chk("mem_en", {31'b0, mem_en}, {31'b0, any});
      chk("mem_wen", {28'b0, mem_wen}, any ? {28'b0, w_wen} : 32'h0);
      chk("mem_addr", mem_addr, any ? w_addr : 32'h0);
      chk("mem_wdata", mem_wdata, any ? w_wdata : 32'h0);
      chk("conflict_cnt", conflict_cnt, m_cnt);

      if (any) begin
        pend.push_back('{owner: win, is_read: (w_wen == 4'h0),
                         data: shadow[w_addr[7:2]], addr: w_addr, due: cyc + LAT});
        for (int b = 0; b < 4; b++)
          if (w_wen[b]) shadow[w_addr[7:2]][8*b +: 8] = w_wdata[8*b +: 8];
        m_prio = ~win;
        glog.push_back('{owner: win, cyc: cyc, data: 32'h0});
      end
      if (inst_req && data_req && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
  end

  // ---------------- stimulus driver: per-port request queues
  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t iq[$];
  txn_t dq[$];
  txn_t i_cur, d_cur;
  logic i_act = 1'b0, d_act = 1'b0;

  task automatic drive();
    inst_req   = i_act;
    inst_wen   = i_act ? i_cur.wen   : 4'h0;
    inst_addr  = i_act ? i_cur.addr  : 32'h0;
    inst_wdata = i_act ? i_cur.wdata : 32'h0;
    data_req   = d_act;
    data_wen   = d_act ? d_cur.wen   : 4'h0;
    data_addr  = d_act ? d_cur.addr  : 32'h0;
    data_wdata = d_act ? d_cur.wdata : 32'h0;
  endtask

  // One clock: note acks mid-cycle, then retire/replace requests after the edge.
  task automatic cycle();
    logic ia, da;
    @(negedge clk);
    ia = inst_ack;
    da = data_ack;
    @(posedge clk);
    #1;
    if (i_act && ia) i_act = 1'b0;
    if (d_act && da) d_act = 1'b0;
    if (!i_act && iq.size() > 0) begin i_cur = iq.pop_front(); i_act = 1'b1; end
    if (!d_act && dq.size() > 0) begin d_cur = dq.pop_front(); d_act = 1'b1; end
    drive();
  endtask

  task automatic drain();
    int n = 0;
    while ((iq.size() > 0 || dq.size() > 0 || i_act || d_act) && n < 300) begin
      cycle();
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: requests still pending after %0d cycles, required 0", n);
    end
    repeat (LAT + 2) cycle();
  endtask

  function automatic txn_t rd(input logic [31:0] a);
    return '{wen: 4'h0, addr: a, wdata: 32'h0};
  endfunction

  function automatic txn_t wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    return '{wen: s, addr: a, wdata: d};
  endfunction

  initial begin
    int ni, nd;
    logic [31:0] c0;
    reset = 1'b0;
    drive();
    repeat (4) cycle();
    reset = 1'b1;

    // contention right after reset: data first, then inst
    glog.delete(); rlog.delete();
    iq.push_back(rd(32'h0)); dq.push_back(rd(32'h4));
    drain();
    chk("cont_grants", glog.size(), 2);
    chk("cont_rsps", rlog.size(), 2);
    if (glog.size() == 2 && rlog.size() == 2) begin
      chk("cont_first_owner", {31'b0, glog[0].owner}, {31'b0, OWN_DATA});
      chk("cont_second_owner", {31'b0, glog[1].owner}, {31'b0, OWN_INST});
      chk("cont_second_cyc", glog[1].cyc, glog[0].cyc + 1);
      chk("cont_rsp0_owner", {31'b0, rlog[0].owner}, {31'b0, OWN_DATA});
      chk("cont_rsp0_lat", rlog[0].cyc - glog[0].cyc, LAT);
      chk("cont_rsp1_owner", {31'b0, rlog[1].owner}, {31'b0, OWN_INST});
      chk("cont_rsp1_cyc", rlog[1].cyc, rlog[0].cyc + 1);
    end
    chk("cont_conflict_cnt", conflict_cnt, 32'd1);

    // preload through the data port
    glog.delete(); rlog.delete();
    dq.push_back(wr(32'h20, 32'hFFFF_FFFF, 4'hF));
    dq.push_back(wr(32'h10, 32'hDEAD_BEEF, 4'hF));
    drain();
    chk("preload_wr_rsps", rlog.size(), 2);

    // single read of 0x10
    glog.delete(); rlog.delete();
    dq.push_back(rd(32'h10));
    drain();
    chk("single_rsps", rlog.size(), 1);
    if (rlog.size() == 1 && glog.size() == 1) begin
      chk("single_owner", {31'b0, rlog[0].owner}, {31'b0, OWN_DATA});
      chk("single_data", rlog[0].data, 32'hDEAD_BEEF);
      chk("single_lat", rlog[0].cyc - glog[0].cyc, LAT);
    end

    // partial write then read back
    glog.delete(); rlog.delete();
    dq.push_back(wr(32'h20, 32'hA5A5_A5A5, 4'b0011));
    dq.push_back(rd(32'h20));
    drain();
    chk("wr_rd_rsps", rlog.size(), 2);
    if (rlog.size() == 2 && glog.size() == 2) begin
      chk("wr_rsp_lat", rlog[0].cyc - glog[0].cyc, LAT);
      chk("wr_rd_data", rlog[1].data, 32'hFFFF_A5A5);
    end

    // pipelined inst reads
    glog.delete(); rlog.delete();
    iq.push_back(rd(32'h10)); iq.push_back(rd(32'h20));
    iq.push_back(rd(32'h0));  iq.push_back(rd(32'h4));
    drain();
    chk("pipe_grants", glog.size(), 4);
    chk("pipe_rsps", rlog.size(), 4);
    if (glog.size() == 4 && rlog.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("pipe_grant_cyc", glog[i].cyc, glog[0].cyc + i);
        chk("pipe_rsp_cyc", rlog[i].cyc, glog[0].cyc + LAT + i);
        chk("pipe_rsp_owner", {31'b0, rlog[i].owner}, {31'b0, OWN_INST});
      end
      chk("pipe_data0", rlog[0].data, 32'hDEAD_BEEF);
      chk("pipe_data1", rlog[1].data, 32'hFFFF_A5A5);
    end

    // reset with two reads in flight
    iq.push_back(rd(32'h10));
    cycle();
    dq.push_back(rd(32'h20));
    cycle();
    cycle();
    reset = 1'b0;
    glog.delete(); rlog.delete();
    repeat (2) cycle();
    reset = 1'b1;
    repeat (8) cycle();
    chk("rst_flight_no_rsp", rlog.size(), 0);
    chk("rst_flight_cnt", conflict_cnt, 32'd0);

    // sustained contention from the reset state
    glog.delete(); rlog.delete();
    for (int i = 0; i < 4; i++) begin
      iq.push_back(rd(32'h40 + 4 * i));
      dq.push_back(rd(32'h80 + 4 * i));
    end
    drain();
    ni = 0; nd = 0;
    foreach (glog[i]) if (glog[i].owner == OWN_DATA) nd++; else ni++;
    chk("sus_inst_grants", ni, 4);
    chk("sus_data_grants", nd, 4);
    chk("sus_conflict_cnt", conflict_cnt, 32'd7);
    if (glog.size() == 8) begin
      chk("sus_first", {31'b0, glog[0].owner}, {31'b0, OWN_DATA});
      chk("sus_last", {31'b0, glog[7].owner}, {31'b0, OWN_INST});
      for (int i = 1; i < 8; i++) begin
        chk("sus_alternate", {31'b0, glog[i].owner}, {31'b0, ~glog[i-1].owner});
        chk("sus_back_to_back", glog[i].cyc, glog[i-1].cyc + 1);
      end
    end

    // randomized traffic, checked by the per-cycle model
    c0 = conflict_cnt;
    for (int k = 0; k < 2500; k++) begin
      if (iq.size() == 0 && $urandom_range(0, 3) != 0)
        iq.push_back('{wen: ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0,
                       addr: 32'($urandom_range(0, 15)) << 2, wdata: $urandom});
      if (dq.size() == 0 && $urandom_range(0, 3) != 0)
        dq.push_back('{wen: ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0,
                       addr: 32'($urandom_range(0, 15)) << 2, wdata: $urandom});
      cycle();
    end
    drain();
    chk("rand_pend_empty", pend.size(), 0);
    chk("rand_conflict_grew", {31'b0, conflict_cnt > c0}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sram_arbiter
